jk_excitation_gen: RTL

Drives a bank of W JK flip-flops so the bank moves to a requested target value. For each target it computes the per-bit J/K excitation from the bank's current outputs, holds it for exactly one clock, then checks the bank's response. Sits between a sequencing controller (valid/ready target stream) and a W-wide bank of the team's JK flip-flops. It is the excitation/control side of the JK flop.

---
 rtl/jk_excitation_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/jk_excitation_gen.sv
// Excitation/control side of a W-wide JK flip-flop bank: drives the bank toward
// each accepted target for one clock, then checks the result. Optional macro: JK_TOGGLE_EN.
module jk_excitation_gen #(
    parameter int W     = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     tgt,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [W-1:0]     q_fb,
    output logic [W-1:0]     j,
    output logic [W-1:0]     k,
    output logic             done,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    input  logic             clr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_e           state_q, state_d;
    logic [W-1:0]     tgt_q, tgt_d;
    logic [W-1:0]     j_q, j_d;
    logic [W-1:0]     k_q, k_d;
    logic             done_q, done_d;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [W-1:0]     exc_j, exc_k;

    // Per-bit excitation from the bank's present value toward the target.
`ifdef JK_TOGGLE_EN
    assign exc_j = q_fb ^ tgt;
    assign exc_k = q_fb ^ tgt;
`else
    assign exc_j = ~q_fb & tgt;
    assign exc_k = q_fb & ~tgt;
`endif

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        j_d        = '0;
        k_d        = '0;
        done_d     = 1'b0;
        mismatch_d = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = tgt;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                state_d    = IDLE;
                done_d     = 1'b1;
                mismatch_d = (q_fb != tgt_q);
                if (mismatch_d && (err_q != ERR_MAX)) begin
                    err_d = err_q + ERR_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear coinciding with an increment must leave the counter at zero.
        if (clr_err) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign mismatch  = mismatch_q;
    assign err_cnt   = err_q;

endmodule
